// File: rtl/conv_result_sink_pkg.sv
// conv_result_sink_pkg
// Shared definitions for the convolution result sink: pixel/word widths,
// the sink state enumeration and the 32-bit -> 8-bit pixel clamp.
// No ports (package).

package conv_result_sink_pkg;

    localparam int PIXEL_W = 8;
    localparam int WORD_W  = 32;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } sink_state_t;

    // Saturate a signed processor result into an unsigned 8-bit pixel.
    // A negative value has its sign bit set. A non-negative value above 255
    // has some bit set between the sign bit and the pixel byte.
    function automatic logic [PIXEL_W-1:0] clamp_pixel(input logic [WORD_W-1:0] value);
        logic [PIXEL_W-1:0] result;
        if (value[WORD_W-1]) begin
            result = '0;
        end else if (|value[WORD_W-2:PIXEL_W]) begin
            result = '1;
        end else begin
            result = value[PIXEL_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/conv_result_sink_sync_fifo.sv
// sync_fifo
// First-word-fall-through FIFO with registered storage. The head entry is
// presented combinationally from the storage array, so a word written in
// cycle N is visible at head_data in cycle N+1.
// Ports:
//   clock, reset      system clock, synchronous active-high reset
//   push, push_data   write request and data (ignored when full)
//   pop               read request (ignored when empty)
//   head_data         oldest stored entry
//   empty, full       occupancy flags

module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign empty     = (count == '0);
    assign full      = (count == (PTR_W+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/conv_result_sink.sv
// conv_result_sink
// Collects signed convolution result triples, clamps each to an 8-bit pixel,
// packs pixels four to a 32-bit word (byte0 = earliest pixel) and queues the
// words in a FWFT FIFO. The last word of each frame carries out_last; a frame
// whose pixel count leaves a partial word is finished by a zero-padded word.
// Ports:
//   clock, reset                     system clock, synchronous active-high reset
//   in_valid, in_ready               input triple handshake
//   in_data0, in_data1, in_data2     signed results, pixel order 0,1,2
//   out_valid, out_ready             output word handshake
//   out_data, out_last               packed pixels and end-of-frame marker
//   frame_done                       pulse when a frame's final word enters the FIFO

module conv_result_sink
    import conv_result_sink_pkg::*;
#(
    parameter int FRAME_PIXELS = 12,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data0,
    input  logic [WORD_W-1:0] in_data1,
    input  logic [WORD_W-1:0] in_data2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last,
    output logic              frame_done
);

    localparam int PIX_W = $clog2(FRAME_PIXELS) + 1;
    localparam logic [PIX_W-1:0] LAST_TRIPLE_START = PIX_W'(FRAME_PIXELS - 3);
    localparam logic [PIX_W-1:0] TRIPLE_STEP       = PIX_W'(3);

    sink_state_t state_q, state_d;

    // Accumulator bytes above acc_cnt_q are always zero, which lets new
    // pixels be OR-ed in and gives the flush word its zero padding for free.
    logic [3*PIXEL_W-1:0] acc_q, acc_d;
    logic [1:0]           acc_cnt_q, acc_cnt_d;
    logic [PIX_W-1:0]     pix_q, pix_d;

    logic                 accept;
    logic                 frame_end;
    logic [3*PIXEL_W-1:0] new_bytes;
    logic [6*PIXEL_W-1:0] merged;

    logic                 fifo_push;
    logic [WORD_W:0]      fifo_push_data;
    logic [WORD_W:0]      fifo_head;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 fifo_pop;
    logic                 done_int;

    assign in_ready  = ~reset & (state_q == RUN) & ~fifo_full;
    assign accept    = in_valid & in_ready;
    assign frame_end = (pix_q == LAST_TRIPLE_START);
    assign new_bytes = {clamp_pixel(in_data2), clamp_pixel(in_data1), clamp_pixel(in_data0)};
    assign merged    = {24'h0, acc_q} | ({24'h0, new_bytes} << {acc_cnt_q, 3'b000});

    assign out_valid  = ~reset & ~fifo_empty;
    assign out_data   = out_valid ? fifo_head[WORD_W-1:0] : '0;
    assign out_last   = out_valid & fifo_head[WORD_W];
    assign frame_done = ~reset & done_int;
    assign fifo_pop   = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= RUN;
            acc_q     <= '0;
            acc_cnt_q <= '0;
            pix_q     <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            acc_cnt_q <= acc_cnt_d;
            pix_q     <= pix_d;
        end
    end

    // Every accept adds three bytes to 0..3 held ones, so a word is pushed
    // exactly when something was already held, and what remains afterwards is
    // one byte fewer than before. A frame end with nothing left over tags
    // that word as last; otherwise FLUSH emits the padded remainder.
    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        acc_cnt_d      = acc_cnt_q;
        pix_d          = pix_q;
        fifo_push      = 1'b0;
        fifo_push_data = '0;
        done_int       = 1'b0;
        case (state_q)
            RUN: begin
                if (accept) begin
                    pix_d = frame_end ? '0 : pix_q + TRIPLE_STEP;
                    if (acc_cnt_q != 2'd0) begin
                        fifo_push      = 1'b1;
                        fifo_push_data = {1'b0, merged[WORD_W-1:0]};
                        acc_d          = {8'h00, merged[6*PIXEL_W-1:WORD_W]};
                        acc_cnt_d      = acc_cnt_q - 2'd1;
                    end else begin
                        acc_d     = merged[3*PIXEL_W-1:0];
                        acc_cnt_d = 2'd3;
                    end
                    if (frame_end) begin
                        if (acc_cnt_q == 2'd1) begin
                            fifo_push_data[WORD_W] = 1'b1;
                            done_int               = 1'b1;
                        end else begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (!fifo_full) begin
                    fifo_push      = 1'b1;
                    fifo_push_data = {1'b1, 8'h00, acc_q};
                    done_int       = 1'b1;
                    acc_d          = '0;
                    acc_cnt_d      = '0;
                    state_d        = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH(WORD_W + 1),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (fifo_push),
        .push_data(fifo_push_data),
        .pop      (fifo_pop),
        .head_data(fifo_head),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

endmodule

// File: tb/tb_conv_result_sink.sv
// tb_conv_result_sink
// Bench for conv_result_sink. The main instance (12-pixel frames) is checked
// every cycle against a byte-queue model of the packing rules; a second
// instance with 6-pixel frames exercises the flush path.

module tb_conv_result_sink;

    logic        clock = 1'b0;
    logic        reset;

    logic        in_valid, out_ready;
    logic [31:0] in_data0, in_data1, in_data2;
    logic        in_ready, out_valid, out_last, frame_done;
    logic [31:0] out_data;

    logic        in_valid_6, out_ready_6;
    logic [31:0] in_data0_6, in_data1_6, in_data2_6;
    logic        in_ready_6, out_valid_6, out_last_6, frame_done_6;
    logic [31:0] out_data_6;

    int pass_count  = 0;
    int check_count = 0;

    always #5 clock = ~clock;

    conv_result_sink #(.FRAME_PIXELS(12), .FIFO_DEPTH(8)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .frame_done(frame_done)
    );

    conv_result_sink #(.FRAME_PIXELS(6), .FIFO_DEPTH(8)) dut6 (
        .clock(clock), .reset(reset),
        .in_valid(in_valid_6), .in_ready(in_ready_6),
        .in_data0(in_data0_6), .in_data1(in_data1_6), .in_data2(in_data2_6),
        .out_valid(out_valid_6), .out_ready(out_ready_6),
        .out_data(out_data_6), .out_last(out_last_6), .frame_done(frame_done_6)
    );

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] required);
        check_count++;
        if (actual === required) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s actual=0x%0h required=0x%0h at %0t", name, actual, required, $time);
        end
    endtask

    // Model: pixels form a byte stream; every four bytes make a word; at the
    // end of each 12-pixel frame any leftover bytes are padded into a last word.
    logic [7:0]  byte_q[$];
    logic [32:0] exp_q[$];
    logic [32:0] log_q[$];
    int          model_pix    = 0;
    int          model_frames = 0;
    int          done_count   = 0;
    bit          prev_stall   = 0;
    logic [32:0] prev_head;

    function automatic logic [7:0] clampRef(input logic signed [31:0] v);
        if (v < 0) return 8'h00;
        if (v > 255) return 8'hFF;
        return v[7:0];
    endfunction

    function automatic void modelAccept(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        logic [32:0] w;
        byte_q.push_back(clampRef(a));
        byte_q.push_back(clampRef(b));
        byte_q.push_back(clampRef(c));
        while (byte_q.size() >= 4) begin
            w = {1'b0, byte_q[3], byte_q[2], byte_q[1], byte_q[0]};
            repeat (4) void'(byte_q.pop_front());
            exp_q.push_back(w);
        end
        model_pix += 3;
        if (model_pix == 12) begin
            model_pix = 0;
            model_frames++;
            if (byte_q.size() == 0) begin
                w = exp_q.pop_back();
                w[32] = 1'b1;
                exp_q.push_back(w);
            end else begin
                w = 33'h1_0000_0000;
                for (int i = 0; i < byte_q.size(); i++) w[8*i +: 8] = byte_q[i];
                exp_q.push_back(w);
                byte_q.delete();
            end
        end
    endfunction

    // Compare process for the main instance.
    always @(negedge clock) begin
        if (reset) begin
            byte_q.delete();
            exp_q.delete();
            model_pix  = 0;
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                checkOutput("hold_valid", {63'b0, out_valid}, 64'd1);
                checkOutput("hold_head", {31'b0, out_last, out_data}, {31'b0, prev_head});
            end
            if (out_valid && out_ready) begin
                checkOutput("word_expected", {63'b0, exp_q.size() != 0}, 64'd1);
                if (exp_q.size() != 0) begin
                    checkOutput("model_word", {31'b0, out_last, out_data}, {31'b0, exp_q.pop_front()});
                end
                log_q.push_back({out_last, out_data});
            end
            if (in_valid && in_ready) modelAccept(in_data0, in_data1, in_data2);
            if (frame_done) done_count++;
            prev_stall = out_valid && !out_ready;
            prev_head  = {out_last, out_data};
        end
    end

    int          low6  = 0;
    int          done6 = 0;
    logic [32:0] log6[$];

    always @(negedge clock) begin
        if (!reset) begin
            if (!in_ready_6) low6++;
            if (frame_done_6) done6++;
            if (out_valid_6 && out_ready_6) log6.push_back({out_last_6, out_data_6});
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Present one triple and hold it until accepted (bounded).
    task automatic applyStimulus(input bit sel, input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        int waited = 0;
        bit done   = 0;
        if (sel) begin
            in_valid_6 = 1'b1; in_data0_6 = a; in_data1_6 = b; in_data2_6 = c;
        end else begin
            in_valid = 1'b1; in_data0 = a; in_data1 = b; in_data2 = c;
        end
        while (!done && waited < 50) begin
            @(negedge clock);
            if (sel ? in_ready_6 : in_ready) done = 1;
            waited++;
        end
        @(posedge clock);
        #1;
        if (sel) in_valid_6 = 1'b0;
        else     in_valid   = 1'b0;
        if (!done) checkOutput("accept_timeout", 64'd0, 64'd1);
    endtask

    task automatic checkLog(input bit sel, input string name, input int idx, input logic [32:0] required);
        logic [63:0] act;
        act = 64'hFFFF_FFFF_FFFF_FFFF;
        if (sel) begin
            if (idx < log6.size()) act = {31'b0, log6[idx]};
        end else begin
            if (idx < log_q.size()) act = {31'b0, log_q[idx]};
        end
        checkOutput(name, act, {31'b0, required});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at %0t", $time);
        $fatal(1, "[TB] watchdog");
    end

    int done_before;

    initial begin
        reset = 1'b1;
        in_valid = 0; out_ready = 0; in_data0 = 0; in_data1 = 0; in_data2 = 0;
        in_valid_6 = 0; out_ready_6 = 0; in_data0_6 = 0; in_data1_6 = 0; in_data2_6 = 0;
        waitCycles(3);

        checkOutput("rst_in_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("rst_out_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("rst_out_data", {32'b0, out_data}, 64'd0);
        checkOutput("rst_out_last", {63'b0, out_last}, 64'd0);
        checkOutput("rst_frame_done", {63'b0, frame_done}, 64'd0);
        checkOutput("rst_in_ready_6", {63'b0, in_ready_6}, 64'd0);
        reset = 1'b0;
        #1;
        checkOutput("in_ready_after_reset", {63'b0, in_ready}, 64'd1);

        // Clamp plus packing across a word boundary, then finish the frame.
        out_ready = 1'b1;
        log_q.delete();
        applyStimulus(0, 32'd10, -32'sd5, 32'd300);
        applyStimulus(0, 32'd1, 32'd2, 32'd3);
        checkOutput("push_latency_valid", {63'b0, out_valid}, 64'd1);
        checkOutput("push_latency_data", {32'b0, out_data}, 64'h01FF000A);
        applyStimulus(0, 32'd4, 32'd5, 32'd6);
        applyStimulus(0, 32'd7, 32'd8, 32'd9);
        waitCycles(3);
        checkLog(0, "mixed_w0", 0, {1'b0, 32'h01FF000A});
        checkLog(0, "mixed_w1", 1, {1'b0, 32'h05040302});
        checkLog(0, "mixed_w2", 2, {1'b1, 32'h09080706});

        // Saturation at both extremes and at the 255/256 boundary.
        log_q.delete();
        applyStimulus(0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd255);
        applyStimulus(0, 32'd256, 32'd7, 32'd8);
        applyStimulus(0, 32'd9, 32'd10, 32'd11);
        applyStimulus(0, 32'hFFFF_FFFF, 32'd1000, 32'd12);
        waitCycles(3);
        checkLog(0, "clamp_w0", 0, {1'b0, 32'hFFFF00FF});
        checkLog(0, "clamp_w1", 1, {1'b0, 32'h0A090807});
        checkLog(0, "clamp_w2", 2, {1'b1, 32'h0CFF000B});

        // Aligned frame: three words, one frame_done, no flush.
        log_q.delete();
        done_before = done_count;
        for (int i = 0; i < 4; i++) applyStimulus(0, 3*i+1, 3*i+2, 3*i+3);
        waitCycles(3);
        checkLog(0, "frame_w0", 0, {1'b0, 32'h04030201});
        checkLog(0, "frame_w1", 1, {1'b0, 32'h08070605});
        checkLog(0, "frame_w2", 2, {1'b1, 32'h0C0B0A09});
        checkOutput("frame_done_pulses", done_count - done_before, 64'd1);

        // Backpressure: FIFO fills after eight words, then drains in order.
        out_ready = 1'b0;
        log_q.delete();
        for (int i = 0; i < 10; i++) applyStimulus(0, 3*i+1, 3*i+2, 3*i+3);
        checkOutput("ready_at_7_words", {63'b0, in_ready}, 64'd1);
        applyStimulus(0, 32'd31, 32'd32, 32'd33);
        checkOutput("ready_at_8_words", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b1; in_data0 = 32'd34; in_data1 = 32'd35; in_data2 = 32'd36;
        waitCycles(3);
        checkOutput("stalled_ready", {63'b0, in_ready}, 64'd0);
        checkOutput("stalled_head", {32'b0, out_data}, 64'h04030201);
        out_ready = 1'b1;
        #1;
        checkOutput("full_pop_still_blocked", {63'b0, in_ready}, 64'd0);
        applyStimulus(0, 32'd34, 32'd35, 32'd36);
        waitCycles(12);
        checkOutput("drain_count", log_q.size(), 64'd9);
        checkLog(0, "drain_first", 0, {1'b0, 32'h04030201});
        checkLog(0, "drain_last", 8, {1'b1, 32'h24232221});

        // Reset mid-frame discards everything.
        out_ready = 1'b0;
        applyStimulus(0, 32'd1, 32'd2, 32'd3);
        applyStimulus(0, 32'd4, 32'd5, 32'd6);
        checkOutput("pre_reset_valid", {63'b0, out_valid}, 64'd1);
        reset = 1'b1;
        waitCycles(1);
        reset = 1'b0;
        #1;
        checkOutput("post_reset_valid", {63'b0, out_valid}, 64'd0);
        checkOutput("post_reset_ready", {63'b0, in_ready}, 64'd1);
        out_ready = 1'b1;
        log_q.delete();
        for (int i = 0; i < 4; i++) applyStimulus(0, 3*i+1, 3*i+2, 3*i+3);
        waitCycles(3);
        checkOutput("clean_frame_count", log_q.size(), 64'd3);
        checkLog(0, "clean_w0", 0, {1'b0, 32'h04030201});
        checkLog(0, "clean_w2", 2, {1'b1, 32'h0C0B0A09});

        // Six-pixel frame ending with two leftover bytes goes through FLUSH.
        out_ready_6 = 1'b1;
        applyStimulus(1, 32'd1, 32'd2, 32'd3);
        applyStimulus(1, 32'd4, 32'd5, 32'd6);
        waitCycles(5);
        checkOutput("flush_ready_low_cycles", low6, 64'd1);
        checkOutput("flush_word_count", log6.size(), 64'd2);
        checkLog(1, "flush_w0", 0, {1'b0, 32'h04030201});
        checkLog(1, "flush_w1", 1, {1'b1, 32'h00000605});
        checkOutput("flush_frame_done", done6, 64'd1);

        checkOutput("model_drained", exp_q.size(), 64'd0);
        checkOutput("model_frames", model_frames, 64'd7);
        checkOutput("frame_done_total", done_count, model_frames);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/conv_result_sink.md
CONV_RESULT_SINK -- requirements
Module: conv_result_sink

Interface
REQ-001 Parameter FRAME_PIXELS, default 12: convolution output pixels per frame; SHALL be a nonzero multiple of 3.
REQ-002 Parameter FIFO_DEPTH, default 8: output word FIFO depth; SHALL be a power of 2 and at least 2.
REQ-003 clock  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  processor result triple present.
REQ-006 in_ready  output  1  block accepts triple this cycle.
REQ-007 in_data0, in_data1, in_data2  input  32 each  signed processor results (output1..output3), pixel order 0,1,2.
REQ-008 out_valid  output  1  FIFO head word valid.
REQ-009 out_ready  input  1  consumer takes head word.
REQ-010 out_data  output  32  four packed 8-bit pixels, byte0 = earliest pixel.
REQ-011 out_last  output  1  head word is final word of frame.
REQ-012 frame_done  output  1  one-cycle pulse when final frame word enters FIFO.

Function
REQ-013 Accept = in_valid & in_ready; transfer out = out_valid & out_ready.
REQ-014 Each in_data SHALL clamp to 8 bits: value < 0 -> 0x00; value > 255 -> 0xFF; else low byte.
REQ-015 Clamped pixels SHALL append to a byte accumulator (0..3 bytes held between accepts) in order 0,1,2.
REQ-016 When the accumulator reaches >= 4 bytes on an accept, the lowest 4 bytes SHALL be pushed into the FIFO in the same cycle, with the remainder retained.
REQ-017 in_ready = (state RUN) & FIFO not full; a same-cycle pop SHALL NOT unblock a full FIFO.
REQ-018 A pixel counter SHALL count accepted pixels; on the accept reaching FRAME_PIXELS, the counter SHALL wrap to 0.
REQ-019 Frame end, remainder 0 after the push: the pushed word SHALL carry last=1; frame_done SHALL pulse that cycle.
REQ-020 Frame end, remainder 1..3: the block SHALL enter FLUSH, hold in_ready=0, and push the remainder zero-padded in high bytes with last=1 once the FIFO is not full; frame_done SHALL pulse on that push; then it SHALL return to RUN.
REQ-021 Frame end with no push and remainder 3: handled per REQ-020 (single padded word).
REQ-022 States: RUN (default), FLUSH; no other states.
REQ-023 FIFO SHALL be first-word-fall-through with registered storage; a word pushed in cycle N SHALL be visible on out_data/out_last with out_valid=1 in cycle N+1.
REQ-024 Simultaneous push and pop on a non-full FIFO SHALL keep occupancy unchanged; pop on empty SHALL be ignored.
REQ-025 out_data/out_last SHALL hold stable while out_valid=1 and out_ready=0.

Reset
REQ-026 During reset: in_ready=0, out_valid=0, out_data=0, out_last=0, frame_done=0.
REQ-027 Reset SHALL clear FIFO, accumulator, pixel counter, and state to RUN; reset mid-frame or mid-FLUSH SHALL discard partial data without emitting a word.
REQ-028 First cycle after reset release: in_ready=1.

Structure
REQ-029 Shared package SHALL hold the state enumeration, PIXEL_W=8, WORD_W=32, and the clamp function.
REQ-030 FIFO SHALL be a sub-module named sync_fifo (parameters width 33 = data+last, depth), storage and occupancy logic only.

Verification
REQ-031 Triples (10,-5,300),(1,2,3) with out_ready=1 -> one word 0x01FF000A, last=0; accumulator holds 0x02,0x03.
REQ-032 Four triples (1..12 in order), FRAME_PIXELS=12 -> words 0x04030201, 0x08070605, 0x0C0B0A09; last=1 only on third; one frame_done pulse; no FLUSH.
REQ-033 FRAME_PIXELS=6, triples (1,2,3),(4,5,6) -> 0x04030201 then 0x00000605 with last=1; in_ready=0 for exactly one cycle (FLUSH).
REQ-034 out_ready=0, continuous input -> in_ready falls after FIFO_DEPTH words; out_data stable; raising out_ready drains words in order with no loss or duplication.
REQ-035 Assert reset for 1 cycle after two triples mid-frame -> FIFO empty, out_valid=0; next four triples (FRAME_PIXELS=12) produce a clean 3-word frame.
REQ-036 Values 0x7FFFFFFF, 0x80000000, 255, 256 -> bytes 0xFF, 0x00, 0xFF, 0xFF.
